// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared widths and MIPS register index constants
package regfile_scoreboard_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int REG_ZERO   = 0;   // $zero
  localparam int REG_RA     = 31;  // $ra, meaningful only when ADDR_W >= 5
endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/writeback bus into the register file
interface regfile_scoreboard_if #(
  parameter int DATA_W = regfile_scoreboard_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_scoreboard_pkg::DEF_ADDR_W
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_ready_a;
  logic              rd_ready_b;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_any;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    input  rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, pend_any
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    output rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, pend_any
  );
endinterface

// File: rtl/regfile_scoreboard_rf_read_port.sv
// rtl/regfile_scoreboard_rf_read_port.sv - one read port: mux, write bypass, ready, optional register
module rf_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [(1<<ADDR_W)-1:0]            pending,
  input  logic                              wrEn,
  input  logic [ADDR_W-1:0]                 wrAddr,
  input  logic [DATA_W-1:0]                 wrData,
  input  logic                              pendSet,
  input  logic [ADDR_W-1:0]                 pendAddr,
  input  logic [ADDR_W-1:0]                 rdAddr,
  output logic [DATA_W-1:0]                 rdData,
  output logic                              rdReady
);
  logic [DATA_W-1:0] dataNext, dataQ;
  logic              readyNext, readyQ;
  logic              hit, isZero;

  always_comb begin
    hit       = (BYPASS != 0) && wrEn && (wrAddr == rdAddr);
    isZero    = (ZERO_REG != 0) && (rdAddr == ADDR_W'(REG_ZERO));
    dataNext  = regs[rdAddr];
    readyNext = ~pending[rdAddr];
    if (hit) begin
      dataNext = wrData;
      // A same-edge pend_set re-arms the register, so the bypass cannot promise ready.
      if (!(pendSet && (pendAddr == rdAddr))) readyNext = 1'b1;
    end
    if (isZero) begin
      dataNext  = '0;
      readyNext = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataQ  <= '0;
      readyQ <= 1'b1;
    end else begin
      dataQ  <= dataNext;
      readyQ <= readyNext;
    end
  end

  assign rdData  = (SYNC_READ != 0) ? dataQ  : dataNext;
  assign rdReady = (SYNC_READ != 0) ? readyQ : readyNext;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 1W/2R register file with per-register pending scoreboard
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pending;
  logic                         wrOk, setOk;

  assign wrOk  = bus.wr_en    && !((ZERO_REG != 0) && (bus.wr_addr   == ADDR_W'(REG_ZERO)));
  assign setOk = bus.pend_set && !((ZERO_REG != 0) && (bus.pend_addr == ADDR_W'(REG_ZERO)));

  // Set is applied after the clear so a new producer issued on the write edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      if (wrOk) begin
        regs[bus.wr_addr]    <= bus.wr_data;
        pending[bus.wr_addr] <= 1'b0;
      end
      if (setOk) pending[bus.pend_addr] <= 1'b1;
    end
  end

  assign bus.pend_any = |pending;

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG),
    .BYPASS(BYPASS), .SYNC_READ(SYNC_READ)
  ) portA (
    .clk(clk), .reset(reset), .regs(regs), .pending(pending),
    .wrEn(bus.wr_en), .wrAddr(bus.wr_addr), .wrData(bus.wr_data),
    .pendSet(bus.pend_set), .pendAddr(bus.pend_addr),
    .rdAddr(bus.rd_addr_a), .rdData(bus.rd_data_a), .rdReady(bus.rd_ready_a)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG),
    .BYPASS(BYPASS), .SYNC_READ(SYNC_READ)
  ) portB (
    .clk(clk), .reset(reset), .regs(regs), .pending(pending),
    .wrEn(bus.wr_en), .wrAddr(bus.wr_addr), .wrData(bus.wr_data),
    .pendSet(bus.pend_set), .pendAddr(bus.pend_addr),
    .rdAddr(bus.rd_addr_b), .rdData(bus.rd_data_b), .rdReady(bus.rd_ready_b)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench: comb/bypass/zero-reg and sync/no-bypass instances
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .SYNC_READ(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0), .SYNC_READ(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  typedef struct {
    int          cyc;
    logic [DW-1:0] da, db;
    logic        ra, rb, pa;
    string       tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] m0[N];
  logic [DW-1:0] m1[N];
  bit p0[N];
  bit p1[N];

  bit          sWrEn, sPendSet;
  int          sWrAddr, sRdA, sRdB, sPendAddr;
  logic [DW-1:0] sWrData;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Model m=0: ZERO_REG=1, BYPASS=1. Model m=1: ZERO_REG=0, BYPASS=0.
  function automatic logic [DW-1:0] expData(input int m, input int a);
    bit special = (m == 0);
    if (special && a == 0) return '0;
    if (special && sWrEn && sWrAddr == a) return sWrData;
    return (m == 0) ? m0[a] : m1[a];
  endfunction

  function automatic logic expReady(input int m, input int a);
    bit special = (m == 0);
    if (special && a == 0) return 1'b1;
    if (special && sWrEn && sWrAddr == a && !(sPendSet && sPendAddr == a)) return 1'b1;
    return (m == 0) ? !p0[a] : !p1[a];
  endfunction

  function automatic logic anyPend(input int m);
    for (int i = 0; i < N; i++) if ((m == 0) ? p0[i] : p1[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    bus0.wr_en = sWrEn;  bus0.wr_addr = AW'(sWrAddr); bus0.wr_data = sWrData;
    bus0.rd_addr_a = AW'(sRdA); bus0.rd_addr_b = AW'(sRdB);
    bus0.pend_set = sPendSet; bus0.pend_addr = AW'(sPendAddr);
    bus1.wr_en = sWrEn;  bus1.wr_addr = AW'(sWrAddr); bus1.wr_data = sWrData;
    bus1.rd_addr_a = AW'(sRdA); bus1.rd_addr_b = AW'(sRdB);
    bus1.pend_set = sPendSet; bus1.pend_addr = AW'(sPendAddr);
  endtask

  task automatic step(input bit we, input int wa, input logic [DW-1:0] wd,
                      input int ra, input int rb, input bit ps, input int pa, input string tag);
    exp_t e0, e1;
    @(posedge clk); #1;
    sWrEn = we; sWrAddr = wa; sWrData = wd; sRdA = ra; sRdB = rb; sPendSet = ps; sPendAddr = pa;
    drive();
    e0.cyc = cyc;     e0.tag = tag;
    e0.da = expData(0, ra); e0.db = expData(0, rb);
    e0.ra = expReady(0, ra); e0.rb = expReady(0, rb); e0.pa = anyPend(0);
    q0.push_back(e0);
    e1.cyc = cyc + 1; e1.tag = {tag, "/sync"};
    e1.da = expData(1, ra); e1.db = expData(1, rb);
    e1.ra = expReady(1, ra); e1.rb = expReady(1, rb);
    if (we && wa != 0) begin m0[wa] = wd; p0[wa] = 0; end
    if (ps && pa != 0) p0[pa] = 1;
    if (we) begin m1[wa] = wd; p1[wa] = 0; end
    if (ps) p1[pa] = 1;
    e1.pa = anyPend(1);
    q1.push_back(e1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      e = q0.pop_front();
      chk({e.tag, " c0.da"}, bus0.rd_data_a, e.da);
      chk({e.tag, " c0.db"}, bus0.rd_data_b, e.db);
      chk({e.tag, " c0.ra"}, DW'(bus0.rd_ready_a), DW'(e.ra));
      chk({e.tag, " c0.rb"}, DW'(bus0.rd_ready_b), DW'(e.rb));
      chk({e.tag, " c0.pany"}, DW'(bus0.pend_any), DW'(e.pa));
    end
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      chk({e.tag, " s1.da"}, bus1.rd_data_a, e.da);
      chk({e.tag, " s1.db"}, bus1.rd_data_b, e.db);
      chk({e.tag, " s1.ra"}, DW'(bus1.rd_ready_a), DW'(e.ra));
      chk({e.tag, " s1.rb"}, DW'(bus1.rd_ready_b), DW'(e.rb));
      chk({e.tag, " s1.pany"}, DW'(bus1.pend_any), DW'(e.pa));
    end
  end

  task automatic resetChecks(input string tag);
    chk({tag, " c0.da"}, bus0.rd_data_a, '0);
    chk({tag, " c0.db"}, bus0.rd_data_b, '0);
    chk({tag, " c0.ra"}, DW'(bus0.rd_ready_a), 1);
    chk({tag, " c0.pany"}, DW'(bus0.pend_any), 0);
    chk({tag, " s1.da"}, bus1.rd_data_a, '0);
    chk({tag, " s1.rb"}, DW'(bus1.rd_ready_b), 1);
    chk({tag, " s1.pany"}, DW'(bus1.pend_any), 0);
  endtask

  // Asserted between edges with a write to a register that no port reads.
  task automatic doReset(input string tag);
    @(posedge clk); @(negedge clk); #1;
    sWrEn = 1; sWrAddr = 3; sWrData = 55; sRdA = 1; sRdB = 2; sPendSet = 1; sPendAddr = 4;
    drive();
    reset = 1'b1;
    #1;
    resetChecks({tag, " async"});
    @(posedge clk); #1;
    resetChecks({tag, " held"});
    @(negedge clk);
    reset = 1'b0;
    sWrEn = 0; sPendSet = 0;
    drive();
    for (int i = 0; i < N; i++) begin m0[i] = '0; m1[i] = '0; p0[i] = 0; p1[i] = 0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sWrEn = 0; sWrAddr = 0; sWrData = '0; sRdA = 0; sRdB = 0; sPendSet = 0; sPendAddr = 0;
    drive();
    for (int i = 0; i < N; i++) begin m0[i] = '0; m1[i] = '0; p0[i] = 0; p1[i] = 0; end
    #12;
    resetChecks("por");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < N; i++) step(1, i, DW'(10 * i), i, N - 1 - i, 0, 0, "fill");
    for (int i = 0; i < N; i++) step(0, 0, '0, i, N - 1 - i, 0, 0, "fillrd");

    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        step(0, $urandom_range(N - 1), DW'(999), a, b, 0, 0, "hold");

    step(1, REG_ZERO, DW'(32'h1234), 0, 0, 1, REG_ZERO, "zwr");
    step(0, 0, '0, 0, 0, 0, 0, "zrd");
    step(0, 0, '0, 0, 0, 0, 0, "zrd2");

    step(1, 5, DW'(50), 1, 1, 0, 0, "byp50");
    step(1, 5, DW'(77), 5, 5, 0, 0, "byp77");
    step(0, 0, '0, 5, 5, 0, 0, "byprd");

    step(0, 0, '0, 7, 7, 1, 7, "pset7");
    step(0, 0, '0, 7, 6, 0, 0, "pend7");
    step(1, 7, DW'(3), 7, 7, 0, 0, "wr7");
    step(0, 0, '0, 7, 7, 0, 0, "rd7");
    step(1, 7, DW'(9), 7, 7, 1, 7, "setwr7");
    step(0, 0, '0, 7, 7, 0, 0, "rd7b");
    step(1, 7, DW'(11), 7, 3, 0, 0, "clr7");

    for (int i = 0; i < 300; i++)
      step($urandom_range(1), $urandom_range(N - 1), $urandom, $urandom_range(N - 1),
           $urandom_range(N - 1), ($urandom_range(3) == 0), $urandom_range(N - 1), "rand");

    doReset("rst");
    for (int i = 0; i < N; i++) step(0, 0, '0, i, N - 1 - i, 0, 0, "postrst");
    for (int i = 0; i < 8; i++) step(1, i, DW'(100 + i), i, i + 1, 0, 0, "refill");
    step(1, 4, DW'(123), 4, 4, 0, 0, "bypass2");
    step(0, 0, '0, 4, 3, 0, 0, "rdback");

    @(posedge clk); @(negedge clk); @(negedge clk); #1;
    chk("drain q0", DW'(q0.size()), 0);
    chk("drain q1", DW'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
